// File: rtl/dbg_scan.sv
// Debug snapshot sequencer: walks the enabled debug regions through chk_addr,
// captures chk_data, and streams one {addr,data} word per location.
module dbg_scan #(
  parameter int CPU_CNT = 65,
  parameter int RF_CNT  = 32,
  parameter int DM_CNT  = 256,
  parameter int SETTLE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  region_mask,
  output logic [15:0] chk_addr,
  input  logic [31:0] chk_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_addr,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND, S_DONE} state_t;

  localparam int MAX_CNT = (CPU_CNT > RF_CNT) ? ((CPU_CNT > DM_CNT) ? CPU_CNT : DM_CNT)
                                              : ((RF_CNT > DM_CNT) ? RF_CNT : DM_CNT);
  localparam int OFF_W = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t            state_q, state_d;
  logic [2:0]        mask_q, mask_d;
  logic [1:0]        region_q, region_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [15:0]       chk_addr_q, chk_addr_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       out_addr_q, out_addr_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic              settle_done;
  logic [OFF_W-1:0]  reg_last;
  logic              nxt_found;
  logic [1:0]        nxt_region;
  logic [1:0]        first_region;
  logic              is_last;

  // State register (with datapath flops)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      region_q    <= '0;
      off_q       <= '0;
      settle_q    <= '0;
      chk_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      region_q    <= region_d;
      off_q       <= off_d;
      settle_q    <= settle_d;
      chk_addr_q  <= chk_addr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Region bookkeeping: last offset of current region, next enabled region above it
  always_comb begin
    settle_done = (settle_q == SET_W'(SETTLE - 1));
    case (region_q)
      2'd0:    reg_last = OFF_W'(CPU_CNT - 1);
      2'd1:    reg_last = OFF_W'(RF_CNT - 1);
      default: reg_last = OFF_W'(DM_CNT - 1);
    endcase
    nxt_found  = 1'b0;
    nxt_region = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(region_q))) begin
        nxt_found  = 1'b1;
        nxt_region = 2'(i);
      end
    end
    first_region = region_mask[0] ? 2'd0 : (region_mask[1] ? 2'd1 : 2'd2);
    is_last      = (off_q == reg_last) && !nxt_found;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (region_mask != 3'b000) ? S_WAIT : S_DONE;
      S_WAIT: if (settle_done) state_d = S_SEND;
      S_SEND: if (out_ready) state_d = out_last_q ? S_DONE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    mask_d      = mask_q;
    region_d    = region_q;
    off_d       = off_q;
    settle_d    = settle_q;
    chk_addr_d  = chk_addr_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    case (state_q)
      S_IDLE: begin
        if (start && (region_mask != 3'b000)) begin
          mask_d   = region_mask;
          region_d = first_region;
          off_d    = '0;
          settle_d = '0;
        end
      end
      S_WAIT: begin
        if (settle_done) begin
          out_valid_d = 1'b1;
          out_addr_d  = chk_addr_q;
          out_data_d  = chk_data;
          out_last_d  = is_last;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (!out_last_q) begin
            settle_d = '0;
            if (off_q == reg_last) begin
              region_d = nxt_region;
              off_d    = '0;
            end else begin
              off_d = off_q + 1'b1;
            end
          end
        end
      end
      default: chk_addr_d = '0;
    endcase
    // The address only moves when a new location is entered
    if ((state_q != S_WAIT) && (state_d == S_WAIT))
      chk_addr_d = {2'b00, region_d, 12'h000} | 16'(off_d);
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  assign chk_addr  = chk_addr_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_dbg_scan.sv
// Self-checking bench for dbg_scan: directed scans with randomized back-pressure,
// checked against an address list built from the region rules.
module tb_dbg_scan;

  localparam int CPU_CNT = 65;
  localparam int RF_CNT  = 32;
  localparam int DM_CNT  = 256;
  localparam int SETTLE  = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  region_mask = 3'b000;
  logic [15:0] chk_addr;
  logic [31:0] chk_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_addr;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [15:0] hi = 16'hC0DE;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // DEBUG mux model: data derived from the address being probed
  assign chk_data = {hi, chk_addr};

  dbg_scan #(
    .CPU_CNT(CPU_CNT), .RF_CNT(RF_CNT), .DM_CNT(DM_CNT), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .region_mask(region_mask),
    .chk_addr(chk_addr), .chk_data(chk_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_chk_addr"}, 32'(chk_addr), 32'h0);
    chk({tag, "_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_out_addr"}, 32'(out_addr), 32'h0);
    chk({tag, "_out_data"}, out_data, 32'h0);
    chk({tag, "_last"}, 32'(out_last), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
  endtask

  // mode 0: ready always high; mode 1: 10-cycle stall at word 3 then random ready;
  // mode 2: stall at word 2 with chk_data disturbed, plus a stray start at word 10
  task automatic run_scan(input logic [2:0] mask, input int mode, input string name);
    int q[$];
    int cyc, words, stall, first_v, done_cyc, last_hs, n, e;
    logic [15:0] ha;
    logic [31:0] hd;
    logic hl, held;
    if (mask[0]) for (int i = 0; i < CPU_CNT; i++) q.push_back(i);
    if (mask[1]) for (int i = 0; i < RF_CNT; i++) q.push_back(32'h1000 + i);
    if (mask[2]) for (int i = 0; i < DM_CNT; i++) q.push_back(32'h2000 + i);
    n = q.size();
    @(negedge clk);
    start = 1'b1;
    region_mask = mask;
    out_ready = 1'b1;
    cyc = 0; words = 0; stall = 0; first_v = -1; done_cyc = -1; last_hs = 0;
    held = 1'b0; ha = '0; hd = '0; hl = 1'b0;
    while (done_cyc < 0 && cyc < 5000) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done) begin
        done_cyc = cyc;
        chk({name, "_busy_in_done"}, 32'(busy), 32'h1);
        chk({name, "_valid_in_done"}, 32'(out_valid), 32'h0);
      end else if (!busy) begin
        chk({name, "_busy"}, 32'(busy), 32'h1);
      end else if (out_valid) begin
        if (first_v < 0) first_v = cyc;
        if (held) begin
          chk({name, "_stall_addr"}, 32'(out_addr), 32'(ha));
          chk({name, "_stall_data"}, out_data, hd);
          chk({name, "_stall_last"}, 32'(out_last), 32'(hl));
        end
        if (q.size() == 0) begin
          chk({name, "_extra_word"}, 32'(out_valid), 32'h0);
          out_ready = 1'b1;
        end else begin
          e = q[0];
          chk({name, "_addr"}, 32'(out_addr), 32'(e));
          chk({name, "_data"}, out_data, {16'hC0DE, e[15:0]});
          chk({name, "_last"}, 32'(out_last), 32'(q.size() == 1));
          case (mode)
            1: begin
              if (words == 3 && stall < 10) begin out_ready = 1'b0; stall++; end
              else out_ready = 1'($urandom_range(0, 1));
            end
            2: begin
              if (words == 2 && stall < 5) begin
                out_ready = 1'b0; hi = 16'hBEEF; stall++;
              end else begin
                out_ready = 1'b1; hi = 16'hC0DE;
              end
              if (words == 10) begin start = 1'b1; region_mask = 3'b111; end
            end
            default: out_ready = 1'b1;
          endcase
          if (out_ready) begin
            void'(q.pop_front());
            words++;
            last_hs = cyc;
            held = 1'b0;
          end else begin
            held = 1'b1; ha = out_addr; hd = out_data; hl = out_last;
          end
        end
      end else begin
        if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      end
    end
    hi = 16'hC0DE;
    chk({name, "_done_seen"}, 32'(done_cyc >= 0), 32'h1);
    chk({name, "_words"}, 32'(words), 32'(n));
    chk({name, "_done_after_last"}, 32'(done_cyc), 32'(last_hs + 1));
    if (n > 0) chk({name, "_first_valid"}, 32'(first_v), 32'(SETTLE + 1));
    else chk({name, "_no_valid"}, 32'(first_v), 32'hFFFFFFFF);
    if (mode == 0) chk({name, "_throughput"}, 32'(done_cyc), 32'((SETTLE + 1) * n + 1));
    @(negedge clk);
    chk({name, "_post_done"}, 32'(done), 32'h0);
    chk({name, "_post_busy"}, 32'(busy), 32'h0);
    chk({name, "_post_addr"}, 32'(chk_addr), 32'h0);
    $display("scan %s mask=%b words=%0d cycles=%0d", name, mask, words, done_cyc);
  endtask

  initial begin
    int seen, guard;
    logic saw_done;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("after_reset");

    run_scan(3'b001, 0, "cpu");
    run_scan(3'b110, 0, "rf_dm");
    run_scan(3'b111, 1, "all_stall");
    run_scan(3'b000, 0, "empty");
    run_scan(3'b011, 2, "ignore_start");

    // Reset partway through a scan: outputs clear, no done pulse
    @(negedge clk);
    start = 1'b1; region_mask = 3'b001; out_ready = 1'b1;
    seen = 0; guard = 0;
    while (seen < 5 && guard < 100) begin
      @(negedge clk);
      start = 1'b0;
      guard++;
      if (out_valid) seen++;
    end
    chk("abort_reached_word5", 32'(seen), 32'd5);
    rst = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_outputs("abort");
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 32'h0);
    $display("abort mask=001 words_before_reset=%0d", seen);
    run_scan(3'b001, 0, "restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
